// File: rtl/program_loader.sv
// program_loader: loads a framed byte stream (length, payload, checksum) into a 16-byte RAM
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   start               begins a frame when idle or after an error
//   rx_data/rx_valid    incoming byte stream; rx_ready accepts it
//   wr_en/wr_addr/wr_data  RAM write port, one strobe per payload byte
//   cpu_hold            keeps the CPU off the RAM whenever not idle
//   busy/done/error     frame in progress, good-frame pulse, sticky failure
module program_loader #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, LEN, DATA, WRITE, CSUM, DONE, ERROR} state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   len, len_n;
    logic [ADDR_W-1:0] addr, addr_n, wr_addr_n;
    logic [7:0]        sum, sum_n, wr_data_n;
    logic [TW-1:0]     tmo, tmo_n;
    logic              rx_st, xfer, expired;

    // every handshake output is decoded from the state register alone
    assign rx_st    = state == LEN || state == DATA || state == CSUM;
    assign rx_ready = rx_st;
    assign wr_en    = state == WRITE;
    assign cpu_hold = state != IDLE;
    assign busy     = rx_st || state == WRITE || state == DONE;
    assign done     = state == DONE;
    assign error    = state == ERROR;
    assign xfer     = rx_st && rx_valid;
    // fires on the TIMEOUT-th consecutive idle cycle in a receiving state
    assign expired  = TIMEOUT != 0 && rx_st && !rx_valid && tmo == TW'(TIMEOUT - 1);

    always_comb begin
        state_n   = state;
        len_n     = len;
        addr_n    = addr;
        sum_n     = sum;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        tmo_n     = (rx_st && !xfer && !expired) ? tmo + 1'b1 : '0;
        case (state)
            IDLE, ERROR: begin
                if (start) begin
                    state_n = LEN;
                    sum_n   = '0;
                    addr_n  = '0;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (rx_data == 8'd0 || rx_data > 8'(DEPTH)) begin
                        state_n = ERROR;
                    end else begin
                        len_n   = rx_data[ADDR_W:0];
                        sum_n   = rx_data;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    wr_data_n = rx_data;
                    wr_addr_n = addr;
                    sum_n     = sum + rx_data;
                    state_n   = WRITE;
                end
            end
            WRITE: begin
                // stop on the last address so L = DEPTH never wraps back to 0
                if ({1'b0, addr} == len - 1'b1) begin
                    state_n = CSUM;
                end else begin
                    addr_n  = addr + 1'b1;
                    state_n = DATA;
                end
            end
            CSUM: begin
                if (xfer) state_n = rx_data == sum ? DONE : ERROR;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (expired) state_n = ERROR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            len     <= '0;
            addr    <= '0;
            sum     <= '0;
            wr_addr <= '0;
            wr_data <= '0;
            tmo     <= '0;
        end else begin
            state   <= state_n;
            len     <= len_n;
            addr    <= addr_n;
            sum     <= sum_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
            tmo     <= tmo_n;
        end
    end
endmodule
